// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl - multi-cycle main control FSM for a shared-memory, single-ALU MIPS
// datapath. Sequences R-type, LW, SW, BEQ and J through fetch, decode,
// execute, memory and write-back states. It waits on a memory ready
// handshake, flags illegal opcodes and counts retired instructions.
//
// Parameters
//   CNT_W        width of the retired-instruction counter
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   op           opcode field IR[31:26]
//   mem_ready    memory completes the current read/write this cycle
//   PCWrite      unconditional PC load
//   PCWriteCond  PC load if ALU zero (BEQ)
//   IorD         memory address select: 0 = PC, 1 = ALUOut
//   MemRead      memory read request
//   MemWrite     memory write request
//   IRWrite      instruction register load
//   MemtoReg     register write data: 0 = ALUOut, 1 = MDR
//   RegDst       write register: 0 = rt, 1 = rd
//   RegWrite     register file write
//   ALUSrcA      0 = PC, 1 = A
//   ALUSrcB      00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
//   ALUOp        00 = add, 01 = sub, 10 = funct-decoded
//   PCSource     00 = ALU result, 01 = ALUOut, 10 = jump target
//   state        current state code (debug)
//   instr_done   one-cycle pulse on the final cycle of each instruction
//   illegal_op   one-cycle pulse when decode sees an unsupported opcode
//   retired      completed-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_retired;

  // Raw decoded controls; strobes are gated by rst_n before leaving the block.
  logic       w_pc_write;
  logic       w_pc_write_cond;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_memto_reg;
  logic       w_reg_dst;
  logic       w_reg_write;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_instr_done;
  logic       w_illegal_op;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_next    = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_iord          = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_memto_reg     = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;

    case (r_state)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle, but PC and IR only load
        // once memory has actually returned the instruction.
        w_mem_read   = 1'b1;
        w_alu_src_b  = 2'b01;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
        w_state_next = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only needs the compare.
        w_alu_src_b = 2'b11;
        case (op)
          OP_RTYPE:      w_state_next = S_EXEC;
          OP_LW, OP_SW:  w_state_next = S_MEMADR;
          OP_BEQ:        w_state_next = S_BRANCH;
          OP_J:          w_state_next = S_JUMP;
          default: begin
            w_state_next = S_FETCH;
            w_illegal_op = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        w_mem_read   = 1'b1;
        w_iord       = 1'b1;
        w_state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_memto_reg  = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end

      S_MEMWR: begin
        // A store retires only on the cycle memory accepts it.
        w_mem_write  = 1'b1;
        w_iord       = 1'b1;
        w_instr_done = mem_ready;
        w_state_next = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_EXEC: begin
        w_alu_src_a  = 1'b1;
        w_alu_op     = 2'b10;
        w_state_next = S_RWB;
      end

      S_RWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = 1'b1;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end

      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 2'b01;
        w_instr_done    = 1'b1;
        w_state_next    = S_FETCH;
      end

      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 2'b10;
        w_instr_done = 1'b1;
        w_state_next = S_FETCH;
      end

      // Unused codes recover to FETCH with all strobes idle.
      default: begin
        w_state_next = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter; natural binary wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_instr_done) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Strobes are forced low while reset is held so nothing downstream
  // commits state during the FETCH value the state register shows in reset.
  assign PCWrite     = rst_n & w_pc_write;
  assign PCWriteCond = rst_n & w_pc_write_cond;
  assign IRWrite     = rst_n & w_ir_write;
  assign MemRead     = rst_n & w_mem_read;
  assign MemWrite    = rst_n & w_mem_write;
  assign RegWrite    = rst_n & w_reg_write;
  assign instr_done  = rst_n & w_instr_done;
  assign illegal_op  = rst_n & w_illegal_op;

  assign IorD        = w_iord;
  assign MemtoReg    = w_memto_reg;
  assign RegDst      = w_reg_dst;
  assign ALUSrcA     = w_alu_src_a;
  assign ALUSrcB     = w_alu_src_b;
  assign ALUOp       = w_alu_op;
  assign PCSource    = w_pc_source;
  assign state       = r_state;
  assign retired     = r_retired;

endmodule

// File: tb/tb_mc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mc_ctrl - directed testbench for mc_ctrl. Two instances share stimulus:
// the default-width one carries most checks, a CNT_W=2 copy checks the wrap.
// -----------------------------------------------------------------------------
module tb_mc_ctrl;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic        mem_ready;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic        instr_done, illegal_op;
  logic [15:0] retired;

  logic        s_pcw, s_pcwc, s_iord, s_mr, s_mw, s_irw, s_m2r, s_rd, s_rw, s_asa;
  logic [1:0]  s_asb, s_aop, s_pcs;
  logic [3:0]  s_state;
  logic        s_done, s_ill;
  logic [1:0]  s_retired;

  int n_tests;
  int n_fail;

  mc_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op), .retired(retired)
  );

  mc_ctrl #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .PCWrite(s_pcw), .PCWriteCond(s_pcwc), .IorD(s_iord),
    .MemRead(s_mr), .MemWrite(s_mw), .IRWrite(s_irw),
    .MemtoReg(s_m2r), .RegDst(s_rd), .RegWrite(s_rw),
    .ALUSrcA(s_asa), .ALUSrcB(s_asb), .ALUOp(s_aop),
    .PCSource(s_pcs), .state(s_state), .instr_done(s_done),
    .illegal_op(s_ill), .retired(s_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one zero-wait R-type from FETCH back to FETCH.
  task automatic run_rtype();
    op = 6'b000000;
    mem_ready = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    op        = 6'b000000;
    mem_ready = 1'b1;

    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state",    32'(state), 32'd0);
    chk("rst_retired",  32'(retired), 32'd0);
    chk("rst_memread",  32'(MemRead), 32'd0);
    chk("rst_irwrite",  32'(IRWrite), 32'd0);
    chk("rst_pcwrite",  32'(PCWrite), 32'd0);
    chk("rst_alusrcb",  32'(ALUSrcB), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(PCWrite), 32'd1);

    // ---------------- R-type ----------------
    tick();
    chk("r_decode", 32'(state), 32'd1);
    tick();
    chk("r_exec", 32'(state), 32'd6);
    chk("r_exec_aluop", 32'(ALUOp), 32'd2);
    chk("r_exec_regwrite", 32'(RegWrite), 32'd0);
    tick();
    chk("r_rwb", 32'(state), 32'd7);
    chk("r_rwb_regwrite", 32'(RegWrite), 32'd1);
    chk("r_rwb_regdst", 32'(RegDst), 32'd1);
    chk("r_rwb_done", 32'(instr_done), 32'd1);
    chk("r_rwb_retired", 32'(retired), 32'd0);
    tick();
    chk("r_back_fetch", 32'(state), 32'd0);
    chk("r_retired", 32'(retired), 32'd1);

    // ---------------- LW with two MEMRD waits ----------------
    op = 6'b100011;
    tick();
    chk("lw_decode", 32'(state), 32'd1);
    tick();
    chk("lw_memadr", 32'(state), 32'd2);
    chk("lw_memadr_alusrcb", 32'(ALUSrcB), 32'd2);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_ready = 1'b1;
      #1;
      chk($sformatf("lw_memrd%0d_state", i), 32'(state), 32'd3);
      chk($sformatf("lw_memrd%0d_read", i), 32'(MemRead), 32'd1);
      chk($sformatf("lw_memrd%0d_iord", i), 32'(IorD), 32'd1);
      tick();
    end
    chk("lw_memwb", 32'(state), 32'd4);
    chk("lw_memwb_memtoreg", 32'(MemtoReg), 32'd1);
    chk("lw_memwb_regwrite", 32'(RegWrite), 32'd1);
    tick();
    chk("lw_back_fetch", 32'(state), 32'd0);
    chk("lw_retired", 32'(retired), 32'd2);

    // ---------------- SW / BEQ / J back-to-back ----------------
    op = 6'b101011;
    tick(); tick();
    chk("sw_memadr", 32'(state), 32'd2);
    tick();
    chk("sw_memwr", 32'(state), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_done", 32'(instr_done), 32'd1);
    tick();
    op = 6'b000100;
    tick(); tick();
    chk("beq_branch", 32'(state), 32'd8);
    chk("beq_pcwc", 32'(PCWriteCond), 32'd1);
    chk("beq_aluop", 32'(ALUOp), 32'd1);
    chk("beq_pcsrc", 32'(PCSource), 32'd1);
    tick();
    op = 6'b000010;
    tick(); tick();
    chk("j_jump", 32'(state), 32'd9);
    chk("j_pcwrite", 32'(PCWrite), 32'd1);
    chk("j_pcsrc", 32'(PCSource), 32'd2);
    tick();
    chk("sbj_fetch", 32'(state), 32'd0);
    chk("sbj_retired", 32'(retired), 32'd5);

    // ---------------- FETCH wait and SW with a MEMWR wait ----------------
    op = 6'b101011;
    mem_ready = 1'b0;
    #1;
    chk("fwait_irwrite", 32'(IRWrite), 32'd0);
    chk("fwait_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    chk("fwait_hold", 32'(state), 32'd0);
    mem_ready = 1'b1;
    tick(); tick(); tick();
    chk("sw2_memwr", 32'(state), 32'd5);
    mem_ready = 1'b0;
    #1;
    chk("sw2_wait_done", 32'(instr_done), 32'd0);
    chk("sw2_wait_memwrite", 32'(MemWrite), 32'd1);
    tick();
    chk("sw2_hold", 32'(state), 32'd5);
    mem_ready = 1'b1;
    tick();
    chk("sw2_retired", 32'(retired), 32'd6);

    // ---------------- illegal opcode ----------------
    op = 6'b111111;
    tick();
    chk("ill_decode", 32'(state), 32'd1);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    chk("ill_done", 32'(instr_done), 32'd0);
    tick();
    chk("ill_fetch", 32'(state), 32'd0);
    chk("ill_retired", 32'(retired), 32'd6);

    // ---------------- reset in MEMRD ----------------
    op = 6'b100011;
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    chk("mid_memrd", 32'(state), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_regwrite", 32'(RegWrite), 32'd0);
    chk("mid_rst_memread", 32'(MemRead), 32'd0);
    chk("mid_rst_retired", 32'(retired), 32'd0);
    mem_ready = 1'b1;
    tick();
    chk("mid_rst_hold_done", 32'(instr_done), 32'd0);
    rst_n = 1'b1;

    // ---------------- counter wrap (CNT_W=2) ----------------
    for (int k = 0; k < 5; k++) run_rtype();
    chk("wrap_w2_retired", 32'(s_retired), 32'd1);
    chk("wrap_w16_retired", 32'(retired), 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop so a stuck run still reports.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
